// File: rtl/ahbl_gpio_port.sv
// AHB-Lite GPIO port: output/direction registers, a 2-flop input synchronizer,
// per-bit edge detection into a sticky W1C status register and a registered IRQ.
module ahbl_gpio_port #(
   parameter logic [31:0] OUT_RST = 32'h0000_0000,
   parameter logic [31:0] OE_RST  = 32'h0000_0000
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic [31:0] HADDR,
   input  logic [1:0]  HTRANS,
   input  logic [2:0]  HSIZE,
   input  logic        HWRITE,
   input  logic        HREADY,
   input  logic [31:0] HWDATA,
   input  logic        HSEL,
   output logic        HREADYOUT,
   output logic [31:0] HRDATA,
   input  logic [31:0] GPIO_IN,
   output logic [31:0] GPIO_OUT,
   output logic [31:0] GPIO_OE,
   output logic        IRQ
);

   localparam logic [2:0] OFF_DATAIN  = 3'd0;
   localparam logic [2:0] OFF_DATAOUT = 3'd1;
   localparam logic [2:0] OFF_DIR     = 3'd2;
   localparam logic [2:0] OFF_IM      = 3'd3;
   localparam logic [2:0] OFF_IS      = 3'd4;
   localparam logic [2:0] OFF_EDGE    = 3'd5;
   localparam logic [2:0] OFF_SET     = 3'd6;
   localparam logic [2:0] OFF_CLR     = 3'd7;

   logic        dp_valid_q, dp_valid_d;
   logic        dp_write_q, dp_write_d;
   logic        dp_word_q,  dp_word_d;
   logic [2:0]  dp_off_q,   dp_off_d;
   logic [31:0] dataout_q,  dataout_d;
   logic [31:0] dir_q,      dir_d;
   logic [31:0] im_q,       im_d;
   logic [31:0] is_q,       is_d;
   logic [31:0] edge_cfg_q, edge_cfg_d;
   logic [31:0] sync1_q,    sync1_d;
   logic [31:0] datain_q,   datain_d;
   logic [31:0] prev_q,     prev_d;
   logic        irq_q,      irq_d;

   logic        addr_valid;
   logic        wr_en;
   logic [31:0] rise;
   logic [31:0] fall;
   logic [31:0] edge_hit;
   logic [31:0] w1c;
   logic        unused_ok;

   assign addr_valid = HSEL & HREADY & HTRANS[1];
   assign wr_en      = dp_valid_q & dp_write_q & dp_word_q;
   assign rise       = datain_q & ~prev_q;
   assign fall       = ~datain_q & prev_q;
   assign edge_hit   = (edge_cfg_q & rise) | (~edge_cfg_q & fall);
   assign unused_ok  = ^{HADDR[31:5], HADDR[1:0], HTRANS[0]};

   always_comb begin
      dp_valid_d = addr_valid;
      dp_write_d = dp_write_q;
      dp_word_d  = dp_word_q;
      dp_off_d   = dp_off_q;
      if (addr_valid) begin
         dp_write_d = HWRITE;
         dp_word_d  = (HSIZE == 3'b010);
         dp_off_d   = HADDR[4:2];
      end

      dataout_d  = dataout_q;
      dir_d      = dir_q;
      im_d       = im_q;
      edge_cfg_d = edge_cfg_q;
      w1c        = '0;
      if (wr_en) begin
         case (dp_off_q)
            OFF_DATAOUT: dataout_d  = HWDATA;
            OFF_DIR:     dir_d      = HWDATA;
            OFF_IM:      im_d       = HWDATA;
            OFF_IS:      w1c        = HWDATA;
            OFF_EDGE:    edge_cfg_d = HWDATA;
            OFF_SET:     dataout_d  = dataout_q | HWDATA;
            OFF_CLR:     dataout_d  = dataout_q & ~HWDATA;
            default:     ;
         endcase
      end

      // A fresh edge outranks a simultaneous W1C of the same bit.
      is_d     = (is_q & ~w1c) | edge_hit;
      sync1_d  = GPIO_IN;
      datain_d = sync1_q;
      prev_d   = datain_q;
      irq_d    = |(is_q & im_q);
   end

   always_ff @(posedge HCLK) begin
      if (!HRESETn) begin
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_word_q  <= 1'b0;
         dp_off_q   <= '0;
         dataout_q  <= OUT_RST;
         dir_q      <= OE_RST;
         im_q       <= '0;
         is_q       <= '0;
         edge_cfg_q <= '0;
         sync1_q    <= '0;
         datain_q   <= '0;
         prev_q     <= '0;
         irq_q      <= 1'b0;
      end else begin
         dp_valid_q <= dp_valid_d;
         dp_write_q <= dp_write_d;
         dp_word_q  <= dp_word_d;
         dp_off_q   <= dp_off_d;
         dataout_q  <= dataout_d;
         dir_q      <= dir_d;
         im_q       <= im_d;
         is_q       <= is_d;
         edge_cfg_q <= edge_cfg_d;
         sync1_q    <= sync1_d;
         datain_q   <= datain_d;
         prev_q     <= prev_d;
         irq_q      <= irq_d;
      end
   end

   // Read data follows the current registers, so a read right after a write sees it.
   always_comb begin
      HRDATA = '0;
      if (dp_valid_q && !dp_write_q) begin
         case (dp_off_q)
            OFF_DATAIN:  HRDATA = datain_q;
            OFF_DATAOUT: HRDATA = dataout_q;
            OFF_DIR:     HRDATA = dir_q;
            OFF_IM:      HRDATA = im_q;
            OFF_IS:      HRDATA = is_q;
            OFF_EDGE:    HRDATA = edge_cfg_q;
            default:     HRDATA = '0;
         endcase
      end
   end

   assign HREADYOUT = 1'b1;
   assign GPIO_OUT  = dataout_q;
   assign GPIO_OE   = dir_q;
   assign IRQ       = irq_q;

endmodule

// File: tb/tb_ahbl_gpio_port.sv
// Bench for ahbl_gpio_port: vector table, directed multi-cycle sequences and
// randomized traffic compared against a pad-history reference model.
module tb_ahbl_gpio_port;

   localparam logic [31:0] OUT_RST = 32'hC0DE_0011;
   localparam logic [31:0] OE_RST  = 32'h0000_FF00;
   localparam logic [1:0]  IDLE = 2'b00, BUSY = 2'b01, NS = 2'b10, SEQ = 2'b11;
   localparam logic [2:0]  O_DATAIN = 3'd0, O_DATAOUT = 3'd1, O_DIR = 3'd2, O_IM = 3'd3;
   localparam logic [2:0]  O_IS = 3'd4, O_EDGE = 3'd5, O_SET = 3'd6, O_CLR = 3'd7;

   logic        HCLK, HRESETn, HWRITE, HREADY, HSEL, HREADYOUT, IRQ;
   logic [31:0] HADDR, HWDATA, HRDATA, GPIO_IN, GPIO_OUT, GPIO_OE;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;

   int checks   = 0;
   int failures = 0;

   ahbl_gpio_port #(.OUT_RST(OUT_RST), .OE_RST(OE_RST)) dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR), .HTRANS(HTRANS), .HSIZE(HSIZE),
      .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA), .HSEL(HSEL),
      .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .GPIO_IN(GPIO_IN),
      .GPIO_OUT(GPIO_OUT), .GPIO_OE(GPIO_OE), .IRQ(IRQ)
   );

   initial begin
      HCLK = 1'b0;
      forever #5 HCLK = ~HCLK;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model: register values plus the pad value seen at each clock edge.
   logic [31:0] m_out, m_dir, m_im, m_is, m_edge;
   logic        m_irq;
   logic        p_valid, p_wr, p_word;
   logic [2:0]  p_off;
   logic [31:0] pad_hist[$];

   task automatic model_edge(input logic rstn, input logic av, input logic wr, input logic word,
                             input logic [2:0] off, input logic [31:0] wd, input logic [31:0] pad);
      logic [31:0] din, prv, events, w1c, old_is, old_im;
      if (!rstn) begin
         m_out = OUT_RST; m_dir = OE_RST; m_im = '0; m_is = '0; m_edge = '0; m_irq = 1'b0;
         p_valid = 1'b0; p_wr = 1'b0; p_word = 1'b0; p_off = '0;
         pad_hist.delete();
         repeat (3) pad_hist.push_back('0);
         return;
      end
      old_is = m_is;
      old_im = m_im;
      din    = pad_hist[1];
      prv    = pad_hist[2];
      events = (m_edge & din & ~prv) | (~m_edge & ~din & prv);
      w1c    = '0;
      if (p_valid && p_wr && p_word) begin
         case (p_off)
            O_DATAOUT: m_out  = wd;
            O_DIR:     m_dir  = wd;
            O_IM:      m_im   = wd;
            O_IS:      w1c    = wd;
            O_EDGE:    m_edge = wd;
            O_SET:     m_out  = m_out | wd;
            O_CLR:     m_out  = m_out & ~wd;
            default:   ;
         endcase
      end
      m_is  = (old_is & ~w1c) | events;
      m_irq = |(old_is & old_im);
      pad_hist.push_front(pad);
      void'(pad_hist.pop_back());
      p_valid = av; p_wr = wr; p_word = word; p_off = off;
   endtask

   function automatic logic [31:0] model_rdata();
      if (!p_valid || p_wr) return '0;
      case (p_off)
         O_DATAIN:  return pad_hist[1];
         O_DATAOUT: return m_out;
         O_DIR:     return m_dir;
         O_IM:      return m_im;
         O_IS:      return m_is;
         O_EDGE:    return m_edge;
         default:   return '0;
      endcase
   endfunction

   task automatic tick();
      logic rstn_c, av_c, wr_c, word_c;
      logic [2:0]  off_c;
      logic [31:0] wd_c, pad_c;
      rstn_c = HRESETn;
      av_c   = HSEL & HREADY & HTRANS[1];
      wr_c   = HWRITE;
      word_c = (HSIZE == 3'd2);
      off_c  = HADDR[4:2];
      wd_c   = HWDATA;
      pad_c  = GPIO_IN;
      @(posedge HCLK);
      #1;
      model_edge(rstn_c, av_c, wr_c, word_c, off_c, wd_c, pad_c);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive_addr(input logic sel, input logic [1:0] trans, input logic wr,
                             input logic [2:0] off, input logic [2:0] size);
      HSEL = sel; HTRANS = trans; HWRITE = wr; HSIZE = size;
      HADDR = {27'd0, off, 2'b00};
   endtask

   task automatic xfer(input logic sel, input logic [1:0] trans, input logic wr,
                       input logic [2:0] off, input logic [2:0] size, input logic [31:0] wd,
                       output logic [31:0] rd);
      drive_addr(sel, trans, wr, off, size);
      tick();
      drive_addr(1'b0, IDLE, 1'b0, 3'd0, 3'd2);
      HWDATA = wd;
      rd = HRDATA;
      tick();
   endtask

   typedef struct {
      logic        sel;
      logic [1:0]  trans;
      logic        wr;
      logic [2:0]  off;
      logic [2:0]  size;
      logic [31:0] wdata;
      logic [31:0] exp_rd;
      logic [31:0] exp_out;
      logic [31:0] exp_oe;
   } vec_t;

   vec_t vecs[$];

   task automatic add_vec(input logic sel, input logic [1:0] trans, input logic wr,
                          input logic [2:0] off, input logic [2:0] size, input logic [31:0] wd,
                          input logic [31:0] erd, input logic [31:0] eout, input logic [31:0] eoe);
      vec_t v;
      v.sel = sel; v.trans = trans; v.wr = wr; v.off = off; v.size = size; v.wdata = wd;
      v.exp_rd = erd; v.exp_out = eout; v.exp_oe = eoe;
      vecs.push_back(v);
   endtask

   initial begin
      logic [31:0] rd;
      HRESETn = 1'b0; HSEL = 1'b0; HTRANS = IDLE; HWRITE = 1'b0; HADDR = '0;
      HSIZE = 3'd2; HREADY = 1'b1; HWDATA = '0; GPIO_IN = '0;
      repeat (3) pad_hist.push_back('0);
      tick();
      tick();
      check("rst_gpio_out", GPIO_OUT, OUT_RST);
      check("rst_gpio_oe", GPIO_OE, OE_RST);
      check("rst_irq", 32'(IRQ), 32'd0);
      check("rst_hreadyout", 32'(HREADYOUT), 32'd1);
      check("rst_hrdata", HRDATA, 32'd0);
      HRESETn = 1'b1;

      add_vec(1, NS,   1, O_DIR,     3'd2, 32'h0000_00FF, 0, OUT_RST,       32'hFF);
      add_vec(1, NS,   1, O_DATAOUT, 3'd2, 32'h1234_5678, 0, 32'h1234_5678, 32'hFF);
      add_vec(1, NS,   0, O_DIR,     3'd2, 0, 32'h0000_00FF, 32'h1234_5678, 32'hFF);
      add_vec(1, NS,   0, O_DATAOUT, 3'd2, 0, 32'h1234_5678, 32'h1234_5678, 32'hFF);
      add_vec(1, NS,   1, O_DATAOUT, 3'd2, 32'h0000_00F0, 0, 32'hF0,        32'hFF);
      add_vec(1, NS,   1, O_SET,     3'd2, 32'h0000_000F, 0, 32'hFF,        32'hFF);
      add_vec(1, NS,   1, O_CLR,     3'd2, 32'h0000_0030, 0, 32'hCF,        32'hFF);
      add_vec(1, NS,   0, O_SET,     3'd2, 0, 0, 32'hCF, 32'hFF);
      add_vec(1, NS,   0, O_CLR,     3'd2, 0, 0, 32'hCF, 32'hFF);
      add_vec(1, NS,   1, O_DATAOUT, 3'd0, 32'hFFFF_FFFF, 0, 32'hCF, 32'hFF);
      add_vec(1, IDLE, 1, O_DIR,     3'd2, 32'hFFFF_FFFF, 0, 32'hCF, 32'hFF);
      add_vec(1, BUSY, 1, O_DATAOUT, 3'd2, 32'hFFFF_FFFF, 0, 32'hCF, 32'hFF);
      add_vec(0, NS,   1, O_DIR,     3'd2, 32'hFFFF_FFFF, 0, 32'hCF, 32'hFF);
      add_vec(1, NS,   1, O_DIR,     3'd1, 32'hFFFF_FFFF, 0, 32'hCF, 32'hFF);
      add_vec(1, SEQ,  1, O_IM,      3'd2, 32'h0000_0005, 0, 32'hCF, 32'hFF);
      add_vec(1, NS,   0, O_IM,      3'd2, 0, 32'h5,  32'hCF, 32'hFF);
      add_vec(1, NS,   1, O_EDGE,    3'd2, 32'h0000_00A5, 0, 32'hCF, 32'hFF);
      add_vec(1, NS,   0, O_EDGE,    3'd2, 0, 32'hA5, 32'hCF, 32'hFF);
      add_vec(1, NS,   1, O_DATAIN,  3'd2, 32'hFFFF_FFFF, 0, 32'hCF, 32'hFF);
      add_vec(1, NS,   0, O_DATAIN,  3'd2, 0, 0, 32'hCF, 32'hFF);
      add_vec(1, IDLE, 0, O_DATAOUT, 3'd2, 0, 0, 32'hCF, 32'hFF);
      add_vec(1, NS,   0, O_IS,      3'd2, 0, 0, 32'hCF, 32'hFF);
      add_vec(1, NS,   0, O_DATAOUT, 3'd0, 0, 32'hCF, 32'hCF, 32'hFF);

      foreach (vecs[i]) begin
         xfer(vecs[i].sel, vecs[i].trans, vecs[i].wr, vecs[i].off, vecs[i].size, vecs[i].wdata, rd);
         check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         check($sformatf("vec%0d_gpio_out", i), GPIO_OUT, vecs[i].exp_out);
         check($sformatf("vec%0d_gpio_oe", i), GPIO_OE, vecs[i].exp_oe);
      end

      // Rising edge on pad 0 through synchronizer, status and IRQ, then W1C.
      xfer(1, NS, 1, O_EDGE, 3'd2, 32'h1, rd);
      xfer(1, NS, 1, O_IM, 3'd2, 32'h1, rd);
      GPIO_IN = 32'h1;
      drive_addr(1, NS, 0, O_DATAIN, 3'd2);
      tick();
      check("edge_datain_c1", HRDATA, 32'h0);
      tick();
      check("edge_datain_c2", HRDATA, 32'h1);
      drive_addr(1, NS, 0, O_IS, 3'd2);
      tick();
      check("edge_is_c3", HRDATA, 32'h1);
      check("edge_irq_c3", 32'(IRQ), 32'd0);
      tick();
      check("edge_irq_c4", 32'(IRQ), 32'd1);
      drive_addr(1, NS, 1, O_IS, 3'd2);
      tick();
      drive_addr(1'b0, IDLE, 1'b0, 3'd0, 3'd2);
      HWDATA = 32'h1;
      tick();
      check("w1c_irq_hold", 32'(IRQ), 32'd1);
      tick();
      check("w1c_irq_clr", 32'(IRQ), 32'd0);
      xfer(1, NS, 0, O_IS, 3'd2, 0, rd);
      check("w1c_is_clr", rd, 32'h0);

      // Reprogramming EDGE while the pad is steady must not raise status.
      xfer(1, NS, 1, O_EDGE, 3'd2, 32'h0, rd);
      xfer(1, NS, 1, O_EDGE, 3'd2, 32'h1, rd);
      xfer(1, NS, 0, O_IS, 3'd2, 0, rd);
      check("edge_cfg_change", rd, 32'h0);

      // W1C landing on the same edge that detects a new rising edge.
      GPIO_IN = 32'h0;
      repeat (4) tick();
      GPIO_IN = 32'h1;
      tick();
      drive_addr(1, NS, 1, O_IS, 3'd2);
      tick();
      drive_addr(1'b0, IDLE, 1'b0, 3'd0, 3'd2);
      HWDATA = 32'h1;
      tick();
      xfer(1, NS, 0, O_IS, 3'd2, 0, rd);
      check("w1c_vs_edge", rd, 32'h1);
      check("irq_before_rst", 32'(IRQ), 32'd1);

      // Back-to-back write then read, then reset in the middle of a write.
      drive_addr(1, NS, 1, O_DATAOUT, 3'd2);
      tick();
      drive_addr(1, NS, 0, O_DATAOUT, 3'd2);
      HWDATA = 32'hA5A5_A5A5;
      tick();
      drive_addr(1'b0, IDLE, 1'b0, 3'd0, 3'd2);
      check("b2b_read", HRDATA, 32'hA5A5_A5A5);
      check("b2b_gpio_out", GPIO_OUT, 32'hA5A5_A5A5);
      tick();
      drive_addr(1, NS, 1, O_DATAOUT, 3'd2);
      tick();
      drive_addr(1'b0, IDLE, 1'b0, 3'd0, 3'd2);
      HWDATA = 32'hDEAD_BEEF;
      HRESETn = 1'b0;
      check("rst_mid_hreadyout", 32'(HREADYOUT), 32'd1);
      tick();
      HRESETn = 1'b1;
      check("rst_mid_gpio_out", GPIO_OUT, OUT_RST);
      check("rst_mid_gpio_oe", GPIO_OE, OE_RST);
      check("rst_mid_irq", 32'(IRQ), 32'd0);
      check("rst_mid_hrdata", HRDATA, 32'h0);
      repeat (4) tick();
      xfer(1, NS, 0, O_IS, 3'd2, 0, rd);
      check("rst_high_pad_edge0", rd, 32'h0);
      xfer(1, NS, 0, O_DATAOUT, 3'd2, 0, rd);
      check("rst_abandoned_write", rd, OUT_RST);

      // Pads held high across reset, with EDGE programmed before the edge arrives.
      HRESETn = 1'b0;
      tick();
      HRESETn = 1'b1;
      drive_addr(1, NS, 1, O_EDGE, 3'd2);
      tick();
      drive_addr(1, NS, 0, O_IS, 3'd2);
      HWDATA = 32'hFFFF_FFFF;
      tick();
      check("rst_rise_c2", HRDATA, 32'h0);
      tick();
      check("rst_rise_c3", HRDATA, 32'h1);
      drive_addr(1'b0, IDLE, 1'b0, 3'd0, 3'd2);

      // Randomized pipelined traffic against the reference model.
      HRESETn = 1'b0;
      tick();
      HRESETn = 1'b1;
      for (int i = 0; i < 1500; i++) begin
         HWDATA  = $urandom;
         HSEL    = ($urandom_range(0, 99) < 85);
         HTRANS  = 2'($urandom_range(0, 3));
         HWRITE  = 1'($urandom_range(0, 1));
         HSIZE   = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(0, 7)) : 3'd2;
         HADDR   = {27'($urandom), 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
         HREADY  = p_valid ? 1'b1 : ($urandom_range(0, 9) != 0);
         GPIO_IN = GPIO_IN ^ ($urandom & $urandom & $urandom);
         HRESETn = ($urandom_range(0, 199) != 0);
         tick();
         check($sformatf("rand%0d_gpio_out", i), GPIO_OUT, m_out);
         check($sformatf("rand%0d_gpio_oe", i), GPIO_OE, m_dir);
         check($sformatf("rand%0d_irq", i), 32'(IRQ), 32'(m_irq));
         check($sformatf("rand%0d_hrdata", i), HRDATA, model_rdata());
         check($sformatf("rand%0d_hreadyout", i), 32'(HREADYOUT), 32'd1);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
